// File: rtl/fence_seq_pkg.sv
// Shared definitions for the fence sequencer: FSM state encoding, watchdog
// width and the bundled output record driven by the output decoder.
package fence_seq_pkg;

    localparam int FENCE_WDOG_W = 16;

    typedef enum logic [2:0] {
        FS_IDLE     = 3'd0,
        FS_DFLUSH   = 3'd1,
        FS_IINVAL   = 3'd2,
        FS_TLBFLUSH = 3'd3,
        FS_DONE     = 3'd4
    } fenceseq_state_t;

    typedef struct packed {
        logic cacheFlushReq;
        logic invalidateICache;
        logic tlbFlush;
        logic fenceStall;
        logic fenceFlush;
        logic fenceDone;
        logic fenceTimeout;
    } fence_outs_t;

    // States in which the fencing instruction is held in M.
    function automatic logic isHoldState(input fenceseq_state_t s);
        return (s == FS_DFLUSH) || (s == FS_IINVAL) || (s == FS_TLBFLUSH);
    endfunction

endpackage

// File: rtl/fence_seq_if.sv
// Memory-stage fence handshake: pipeline requests in, maintenance strobes and
// hazard-unit controls out. master = pipeline side, slave = sequencer side.
interface fence_seq_if;

    logic FenceIM;
    logic SFenceVmaM;
    logic TrapM;
    logic CacheFlushAckM;
    logic CacheFlushReqM;
    logic InvalidateICacheM;
    logic TLBFlushM;
    logic FenceStallM;
    logic FenceFlushM;
    logic FenceDoneM;
    logic FenceTimeoutM;

    modport master (
        output FenceIM,
        output SFenceVmaM,
        output TrapM,
        output CacheFlushAckM,
        input  CacheFlushReqM,
        input  InvalidateICacheM,
        input  TLBFlushM,
        input  FenceStallM,
        input  FenceFlushM,
        input  FenceDoneM,
        input  FenceTimeoutM
    );

    modport slave (
        input  FenceIM,
        input  SFenceVmaM,
        input  TrapM,
        input  CacheFlushAckM,
        output CacheFlushReqM,
        output InvalidateICacheM,
        output TLBFlushM,
        output FenceStallM,
        output FenceFlushM,
        output FenceDoneM,
        output FenceTimeoutM
    );

endinterface

// File: rtl/fence_seq_wdog.sv
// D$ flush watchdog: saturating cycle counter with synchronous clear and a
// combinational expiry flag raised on the last allowed cycle.
module fence_wdog
    import fence_seq_pkg::*;
#(
    parameter int LIMIT = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    en,
    output logic                    expired,
    output logic [FENCE_WDOG_W-1:0] count
);

    localparam bit                    ENABLED = (LIMIT != 0);
    localparam logic [FENCE_WDOG_W-1:0] LIMIT_V = FENCE_WDOG_W'(LIMIT);
    localparam logic [FENCE_WDOG_W-1:0] LAST_V  = LIMIT_V - FENCE_WDOG_W'(1);

    logic [FENCE_WDOG_W-1:0] countReg;
    logic [FENCE_WDOG_W-1:0] countNext;

    always_comb begin
        countNext = countReg;
        if (clr || !ENABLED) begin
            countNext = '0;
        end else if (en && (countReg != LIMIT_V)) begin
            countNext = countReg + FENCE_WDOG_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            countReg <= '0;
        end else begin
            countReg <= countNext;
        end
    end

    // en already excludes the ack cycle, so an ack on the last cycle wins.
    assign expired = ENABLED && en && (countReg == LAST_V);
    assign count   = countReg;

endmodule

// File: rtl/fence_seq.sv
// Memory-stage fence sequencer: holds FENCE.I / SFENCE.VMA in M while the
// D$ flush, I$ invalidate and TLB flush run, then flushes younger instructions.
module fence_seq
    import fence_seq_pkg::*;
#(
    parameter bit DCACHE_SUPPORTED  = 1'b1,
    parameter bit ICACHE_SUPPORTED  = 1'b1,
    parameter bit VIRTMEM_SUPPORTED = 1'b1,
    parameter int FLUSH_TIMEOUT     = 0
) (
    input  logic        clk,
    input  logic        reset,
    fence_seq_if.slave  fenceBus
);

    fenceseq_state_t stateReg;
    fenceseq_state_t stateNext;
    logic            timeoutReg;
    logic            timeoutNext;

    logic            start;
    logic            flushAck;
    logic            wdogClr;
    logic            wdogEn;
    logic            wdogExpired;
    logic [FENCE_WDOG_W-1:0] wdogCount;
    fence_outs_t     outs;

    assign start = (stateReg == FS_IDLE)
                 & (fenceBus.FenceIM | fenceBus.SFenceVmaM)
                 & ~fenceBus.TrapM;

    // Acks arriving outside DFLUSH are stray and must not steer anything.
    assign flushAck = (stateReg == FS_DFLUSH) & fenceBus.CacheFlushAckM;

    assign wdogClr = start;
    assign wdogEn  = (stateReg == FS_DFLUSH) & ~fenceBus.CacheFlushAckM;

    fence_wdog #(
        .LIMIT (FLUSH_TIMEOUT)
    ) wdog (
        .clk     (clk),
        .reset   (reset),
        .clr     (wdogClr),
        .en      (wdogEn),
        .expired (wdogExpired),
        .count   (wdogCount)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            stateReg   <= FS_IDLE;
            timeoutReg <= 1'b0;
        end else begin
            stateReg   <= stateNext;
            timeoutReg <= timeoutNext;
        end
    end

    always_comb begin
        stateNext   = stateReg;
        timeoutNext = timeoutReg | wdogExpired;
        unique case (stateReg)
            FS_IDLE: begin
                if (start) begin
                    // FENCE.I wins when both fence types are presented together.
                    if (fenceBus.FenceIM) begin
                        stateNext = DCACHE_SUPPORTED ? FS_DFLUSH : FS_IINVAL;
                    end else begin
                        stateNext = VIRTMEM_SUPPORTED ? FS_TLBFLUSH : FS_DONE;
                    end
                end
            end
            FS_DFLUSH: begin
                if (flushAck || wdogExpired) begin
                    stateNext = FS_IINVAL;
                end
            end
            FS_IINVAL:   stateNext = FS_DONE;
            FS_TLBFLUSH: stateNext = FS_DONE;
            FS_DONE:     stateNext = FS_IDLE;
            default:     stateNext = FS_IDLE;
        endcase
    end

    // Outputs are forced low during reset so an abandoned flush request drops at once.
    always_comb begin
        outs = '0;
        if (!reset) begin
            outs.fenceStall   = start | isHoldState(stateReg);
            outs.fenceTimeout = timeoutReg;
            unique case (stateReg)
                FS_DFLUSH:   outs.cacheFlushReq    = 1'b1;
                FS_IINVAL:   outs.invalidateICache = ICACHE_SUPPORTED;
                FS_TLBFLUSH: outs.tlbFlush         = 1'b1;
                FS_DONE: begin
                    outs.fenceDone  = 1'b1;
                    outs.fenceFlush = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign fenceBus.CacheFlushReqM    = outs.cacheFlushReq;
    assign fenceBus.InvalidateICacheM = outs.invalidateICache;
    assign fenceBus.TLBFlushM         = outs.tlbFlush;
    assign fenceBus.FenceStallM       = outs.fenceStall;
    assign fenceBus.FenceFlushM       = outs.fenceFlush;
    assign fenceBus.FenceDoneM        = outs.fenceDone;
    assign fenceBus.FenceTimeoutM     = outs.fenceTimeout;

`ifndef SYNTHESIS
    pulseExclusive: assert property (@(posedge clk) disable iff (reset)
        $onehot0({outs.invalidateICache, outs.tlbFlush, outs.fenceDone}));

    wdogInRange: assert property (@(posedge clk) disable iff (reset)
        (FLUSH_TIMEOUT == 0) || (wdogCount <= FENCE_WDOG_W'(FLUSH_TIMEOUT)));
`endif

endmodule

// File: tb/tb_fence_seq.sv
// Directed bench for fence_seq: three configurations share one stimulus bus;
// a vector table checks the default core, hand sequences cover the others.
module tb_fence_seq;

    import fence_seq_pkg::*;

    // Output vector order: {req, inval, tlb, stall, flush, done, timeout}
    localparam logic [6:0] O_IDLE  = 7'b0000000;
    localparam logic [6:0] O_START = 7'b0001000;
    localparam logic [6:0] O_DFL   = 7'b1001000;
    localparam logic [6:0] O_INV   = 7'b0101000;
    localparam logic [6:0] O_TLB   = 7'b0011000;
    localparam logic [6:0] O_DONE  = 7'b0000110;
    localparam logic [6:0] O_TMO   = 7'b0000001;

    typedef struct {
        logic       rst;
        logic       fi;
        logic       sf;
        logic       tr;
        logic       ak;
        logic [6:0] exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic fenceI, sfence, trap, ack;
    logic [6:0] outs [3];
    vec_t vecs[$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // 0: default core; 1: 4-cycle watchdog, no VM; 2: no D$, no I$.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : gDut
            fence_seq_if bus ();
            assign bus.FenceIM        = fenceI;
            assign bus.SFenceVmaM     = sfence;
            assign bus.TrapM          = trap;
            assign bus.CacheFlushAckM = ack;
            fence_seq #(
                .DCACHE_SUPPORTED  (gi != 2),
                .ICACHE_SUPPORTED  (gi != 2),
                .VIRTMEM_SUPPORTED (gi != 1),
                .FLUSH_TIMEOUT     ((gi == 1) ? 4 : 0)
            ) dut (
                .clk      (clk),
                .reset    (reset),
                .fenceBus (bus)
            );
            assign outs[gi] = {bus.CacheFlushReqM, bus.InvalidateICacheM, bus.TLBFlushM,
                               bus.FenceStallM, bus.FenceFlushM, bus.FenceDoneM,
                               bus.FenceTimeoutM};
        end
    endgenerate

    task automatic addVec(input logic rst, input logic fi, input logic sf,
                          input logic tr, input logic ak, input logic [6:0] e);
        vec_t v;
        v.rst = rst; v.fi = fi; v.sf = sf; v.tr = tr; v.ak = ak; v.exp = e;
        vecs.push_back(v);
    endtask

    // One cycle: drive inputs, compare outputs mid-cycle, advance past the edge.
    task automatic stepCheck(input string name, input int d, input logic rst,
                             input logic fi, input logic sf, input logic tr,
                             input logic ak, input logic [6:0] e);
        reset = rst; fenceI = fi; sfence = sf; trap = tr; ack = ak;
        @(negedge clk);
        tests++;
        if (outs[d] !== e) begin
            fails++;
            $display("FAIL %s dut%0d: got %b want %b", name, d, outs[d], e);
        end else begin
            $display("ok   %s dut%0d: %b", name, d, outs[d]);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL global time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1; fenceI = 1'b0; sfence = 1'b0; trap = 1'b0; ack = 1'b0;
        #1;

        // rst fi sf tr ak expected (default configuration)
        addVec(1, 0, 0, 0, 0, O_IDLE);
        addVec(1, 1, 0, 0, 0, O_IDLE);
        addVec(0, 0, 0, 0, 0, O_IDLE);
        addVec(0, 0, 0, 0, 1, O_IDLE);
        addVec(0, 1, 0, 1, 0, O_IDLE);
        addVec(0, 1, 0, 0, 0, O_START);
        addVec(0, 1, 0, 0, 0, O_DFL);
        addVec(0, 1, 0, 0, 0, O_DFL);
        addVec(0, 1, 0, 0, 0, O_DFL);
        addVec(0, 1, 0, 0, 0, O_DFL);
        addVec(0, 1, 0, 0, 1, O_DFL);
        addVec(0, 1, 0, 0, 0, O_INV);
        addVec(0, 1, 0, 0, 0, O_DONE);
        addVec(0, 0, 0, 0, 0, O_IDLE);
        addVec(0, 0, 1, 0, 0, O_START);
        addVec(0, 0, 1, 1, 0, O_TLB);
        addVec(0, 0, 1, 0, 0, O_DONE);
        addVec(0, 0, 0, 0, 0, O_IDLE);
        addVec(0, 1, 1, 0, 0, O_START);
        addVec(0, 1, 1, 0, 0, O_DFL);
        addVec(0, 1, 1, 0, 1, O_DFL);
        addVec(0, 1, 1, 0, 0, O_INV);
        addVec(0, 1, 1, 0, 0, O_DONE);
        addVec(0, 0, 0, 0, 1, O_IDLE);
        addVec(0, 1, 0, 0, 0, O_START);
        addVec(0, 1, 0, 1, 0, O_DFL);
        addVec(0, 1, 0, 0, 0, O_DFL);
        addVec(1, 1, 0, 0, 0, O_IDLE);
        addVec(0, 0, 0, 0, 0, O_IDLE);
        addVec(0, 1, 0, 0, 0, O_START);
        addVec(0, 1, 0, 0, 1, O_DFL);
        addVec(0, 1, 0, 0, 0, O_INV);
        addVec(0, 1, 0, 0, 0, O_DONE);
        addVec(0, 0, 0, 0, 0, O_IDLE);

        foreach (vecs[i]) begin
            stepCheck($sformatf("vec%0d", i), 0, vecs[i].rst, vecs[i].fi,
                      vecs[i].sf, vecs[i].tr, vecs[i].ak, vecs[i].exp);
        end

        // Watchdog expiry without ack, then a prompt-ack fence; error stays sticky.
        stepCheck("tmo_reset",  1, 1, 0, 0, 0, 0, O_IDLE);
        stepCheck("tmo_start",  1, 0, 1, 0, 0, 0, O_START);
        for (int c = 1; c <= 4; c++) begin
            stepCheck($sformatf("tmo_dfl%0d", c), 1, 0, 1, 0, 0, 0, O_DFL);
        end
        stepCheck("tmo_inval",  1, 0, 1, 0, 0, 0, O_INV | O_TMO);
        stepCheck("tmo_done",   1, 0, 1, 0, 0, 0, O_DONE | O_TMO);
        stepCheck("tmo_idle",   1, 0, 0, 0, 0, 0, O_TMO);
        stepCheck("tmo2_start", 1, 0, 1, 0, 0, 0, O_START | O_TMO);
        stepCheck("tmo2_ack",   1, 0, 1, 0, 0, 1, O_DFL | O_TMO);
        stepCheck("tmo2_inval", 1, 0, 1, 0, 0, 0, O_INV | O_TMO);
        stepCheck("tmo2_done",  1, 0, 1, 0, 0, 0, O_DONE | O_TMO);
        stepCheck("tmo2_idle",  1, 0, 0, 0, 0, 0, O_TMO);
        stepCheck("tmo_clrrst", 1, 1, 0, 0, 0, 0, O_IDLE);
        stepCheck("tmo_cleared",1, 0, 0, 0, 0, 0, O_IDLE);

        // Ack lands exactly in the expiry cycle: normal completion, no error.
        stepCheck("edge_start", 1, 0, 1, 0, 0, 0, O_START);
        for (int c = 1; c <= 3; c++) begin
            stepCheck($sformatf("edge_dfl%0d", c), 1, 0, 1, 0, 0, 0, O_DFL);
        end
        stepCheck("edge_ack",   1, 0, 1, 0, 0, 1, O_DFL);
        stepCheck("edge_inval", 1, 0, 1, 0, 0, 0, O_INV);
        stepCheck("edge_done",  1, 0, 1, 0, 0, 0, O_DONE);
        stepCheck("edge_idle",  1, 0, 0, 0, 0, 0, O_IDLE);

        // SFENCE.VMA without virtual memory goes straight to DONE.
        stepCheck("novm_start", 1, 0, 0, 1, 0, 0, O_START);
        stepCheck("novm_done",  1, 0, 0, 1, 0, 0, O_DONE);
        stepCheck("novm_idle",  1, 0, 0, 0, 0, 0, O_IDLE);

        // No caches: FENCE.I skips DFLUSH and the invalidate pulse is suppressed.
        stepCheck("noc_reset",  2, 1, 0, 0, 0, 0, O_IDLE);
        stepCheck("noc_start",  2, 0, 1, 0, 0, 0, O_START);
        stepCheck("noc_inval",  2, 0, 1, 0, 0, 0, O_START);
        stepCheck("noc_done",   2, 0, 1, 0, 0, 0, O_DONE);
        stepCheck("noc_idle",   2, 0, 0, 0, 0, 1, O_IDLE);
        stepCheck("noc_sstart", 2, 0, 0, 1, 0, 0, O_START);
        stepCheck("noc_tlb",    2, 0, 0, 1, 0, 0, O_TLB);
        stepCheck("noc_sdone",  2, 0, 0, 1, 0, 0, O_DONE);
        stepCheck("noc_sidle",  2, 0, 0, 0, 0, 0, O_IDLE);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
